// File: rtl/alu_rs.sv
// alu_rs: reservation station in front of the integer ALU.
// It holds decoded ALU instructions until both source operands are known. Operands are
// captured from the ALU and LSB result buses. Each cycle it sends the lowest-index ready
// entry to the ALU.
//
// Ports:
//   clk, rst_n                 clock (rising edge), asynchronous active-low reset
//   rdy                        global enable; low holds all state
//   clear                      synchronous flush; highest priority
//   issue_*                    instruction from the decoder (op, pc, imm, rob tag, operands)
//   alu_cdb_*, lsb_cdb_*       result broadcasts (valid, rob tag, value)
//   rs_full                    no free entry; decoder must not issue
//   alu_work, alu_*            registered dispatch strobe and operand bundle to the ALU
module alu_rs #(
   parameter int unsigned RS_SIZE = 16,
   parameter int unsigned ROB_W   = 4,
   parameter int unsigned OP_W    = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             rdy,
   input  logic             clear,
   input  logic             issue_valid,
   input  logic [OP_W-1:0]  issue_op,
   input  logic [31:0]      issue_pc,
   input  logic [31:0]      issue_imm,
   input  logic [ROB_W-1:0] issue_rob_pos,
   input  logic             issue_qj_busy,
   input  logic [ROB_W-1:0] issue_qj,
   input  logic [31:0]      issue_vj,
   input  logic             issue_qk_busy,
   input  logic [ROB_W-1:0] issue_qk,
   input  logic [31:0]      issue_vk,
   input  logic             alu_cdb_valid,
   input  logic [ROB_W-1:0] alu_cdb_rob,
   input  logic [31:0]      alu_cdb_val,
   input  logic             lsb_cdb_valid,
   input  logic [ROB_W-1:0] lsb_cdb_rob,
   input  logic [31:0]      lsb_cdb_val,
   output logic             rs_full,
   output logic             alu_work,
   output logic [OP_W-1:0]  alu_op,
   output logic [31:0]      alu_pc,
   output logic [31:0]      alu_rs1,
   output logic [31:0]      alu_rs2,
   output logic [31:0]      alu_imm,
   output logic [ROB_W-1:0] alu_rob_pos
);

   localparam int unsigned IDX_W = $clog2(RS_SIZE);
   localparam int unsigned CNT_W = IDX_W + 1;

   logic [RS_SIZE-1:0] busy_q;
   logic [RS_SIZE-1:0] qj_busy_q;
   logic [RS_SIZE-1:0] qk_busy_q;
   logic [OP_W-1:0]    op_q      [RS_SIZE];
   logic [31:0]        pc_q      [RS_SIZE];
   logic [31:0]        imm_q     [RS_SIZE];
   logic [ROB_W-1:0]   rob_q     [RS_SIZE];
   logic [ROB_W-1:0]   qj_q      [RS_SIZE];
   logic [ROB_W-1:0]   qk_q      [RS_SIZE];
   logic [31:0]        vj_q      [RS_SIZE];
   logic [31:0]        vk_q      [RS_SIZE];
   logic [CNT_W-1:0]   count_q;
   logic [CNT_W-1:0]   count_d;

   logic               free_found;
   logic [IDX_W-1:0]   free_idx;
   logic               ready_found;
   logic [IDX_W-1:0]   ready_idx;
   logic               do_issue;
   logic               iss_qj_busy;
   logic [31:0]        iss_vj;
   logic               iss_qk_busy;
   logic [31:0]        iss_vk;

   assign rs_full  = (count_q == CNT_W'(RS_SIZE));
   assign do_issue = issue_valid && !rs_full && free_found;

   // Lowest-index free slot and lowest-index ready slot, both from registered state so an
   // instruction never dispatches on the edge that issues or wakes it.
   always_comb begin
      free_found  = 1'b0;
      free_idx    = '0;
      ready_found = 1'b0;
      ready_idx   = '0;
      for (int unsigned i = 0; i < RS_SIZE; i++) begin
         if (!busy_q[IDX_W'(i)] && !free_found) begin
            free_found = 1'b1;
            free_idx   = IDX_W'(i);
         end
         if (busy_q[IDX_W'(i)] && !qj_busy_q[IDX_W'(i)] && !qk_busy_q[IDX_W'(i)]
             && !ready_found) begin
            ready_found = 1'b1;
            ready_idx   = IDX_W'(i);
         end
      end
   end

   // Issue-time bypass: an operand produced on a bus in the issue cycle is captured directly.
   always_comb begin
      iss_qj_busy = issue_qj_busy;
      iss_vj      = issue_vj;
      if (issue_qj_busy && alu_cdb_valid && (alu_cdb_rob == issue_qj)) begin
         iss_qj_busy = 1'b0;
         iss_vj      = alu_cdb_val;
      end else if (issue_qj_busy && lsb_cdb_valid && (lsb_cdb_rob == issue_qj)) begin
         iss_qj_busy = 1'b0;
         iss_vj      = lsb_cdb_val;
      end
      iss_qk_busy = issue_qk_busy;
      iss_vk      = issue_vk;
      if (issue_qk_busy && alu_cdb_valid && (alu_cdb_rob == issue_qk)) begin
         iss_qk_busy = 1'b0;
         iss_vk      = alu_cdb_val;
      end else if (issue_qk_busy && lsb_cdb_valid && (lsb_cdb_rob == issue_qk)) begin
         iss_qk_busy = 1'b0;
         iss_vk      = lsb_cdb_val;
      end
   end

   always_comb begin
      count_d = count_q;
      if (do_issue && !ready_found) begin
         count_d = count_q + CNT_W'(1);
      end else if (!do_issue && ready_found) begin
         count_d = count_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q      <= '0;
         qj_busy_q   <= '0;
         qk_busy_q   <= '0;
         count_q     <= '0;
         alu_work    <= 1'b0;
         alu_op      <= '0;
         alu_pc      <= '0;
         alu_rs1     <= '0;
         alu_rs2     <= '0;
         alu_imm     <= '0;
         alu_rob_pos <= '0;
         for (int unsigned i = 0; i < RS_SIZE; i++) begin
            op_q[IDX_W'(i)]  <= '0;
            pc_q[IDX_W'(i)]  <= '0;
            imm_q[IDX_W'(i)] <= '0;
            rob_q[IDX_W'(i)] <= '0;
            qj_q[IDX_W'(i)]  <= '0;
            qk_q[IDX_W'(i)]  <= '0;
            vj_q[IDX_W'(i)]  <= '0;
            vk_q[IDX_W'(i)]  <= '0;
         end
      end else if (!rdy) begin
         alu_work <= 1'b0;
      end else if (clear) begin
         busy_q   <= '0;
         count_q  <= '0;
         alu_work <= 1'b0;
      end else begin
         // Wakeup of waiting operands in busy entries
         for (int unsigned i = 0; i < RS_SIZE; i++) begin
            if (busy_q[IDX_W'(i)] && qj_busy_q[IDX_W'(i)]) begin
               if (alu_cdb_valid && (alu_cdb_rob == qj_q[IDX_W'(i)])) begin
                  vj_q[IDX_W'(i)]      <= alu_cdb_val;
                  qj_busy_q[IDX_W'(i)] <= 1'b0;
               end else if (lsb_cdb_valid && (lsb_cdb_rob == qj_q[IDX_W'(i)])) begin
                  vj_q[IDX_W'(i)]      <= lsb_cdb_val;
                  qj_busy_q[IDX_W'(i)] <= 1'b0;
               end
            end
            if (busy_q[IDX_W'(i)] && qk_busy_q[IDX_W'(i)]) begin
               if (alu_cdb_valid && (alu_cdb_rob == qk_q[IDX_W'(i)])) begin
                  vk_q[IDX_W'(i)]      <= alu_cdb_val;
                  qk_busy_q[IDX_W'(i)] <= 1'b0;
               end else if (lsb_cdb_valid && (lsb_cdb_rob == qk_q[IDX_W'(i)])) begin
                  vk_q[IDX_W'(i)]      <= lsb_cdb_val;
                  qk_busy_q[IDX_W'(i)] <= 1'b0;
               end
            end
         end

         // Dispatch; alu_* data hold their value when nothing is ready
         alu_work <= ready_found;
         if (ready_found) begin
            alu_op            <= op_q[ready_idx];
            alu_pc            <= pc_q[ready_idx];
            alu_rs1           <= vj_q[ready_idx];
            alu_rs2           <= vk_q[ready_idx];
            alu_imm           <= imm_q[ready_idx];
            alu_rob_pos       <= rob_q[ready_idx];
            busy_q[ready_idx] <= 1'b0;
         end

         // Issue into a slot that was free before this edge; never the one just dispatched
         if (do_issue) begin
            busy_q[free_idx]    <= 1'b1;
            op_q[free_idx]      <= issue_op;
            pc_q[free_idx]      <= issue_pc;
            imm_q[free_idx]     <= issue_imm;
            rob_q[free_idx]     <= issue_rob_pos;
            qj_q[free_idx]      <= issue_qj;
            qk_q[free_idx]      <= issue_qk;
            qj_busy_q[free_idx] <= iss_qj_busy;
            qk_busy_q[free_idx] <= iss_qk_busy;
            vj_q[free_idx]      <= iss_vj;
            vk_q[free_idx]      <= iss_vk;
         end

         count_q <= count_d;
      end
   end

endmodule

// File: doc/alu_rs.md
Name: alu_rs

Overview:
- Reservation station feeding the integer ALU in the Tomasulo out-of-order core.
- Buffers decoded arithmetic/logic instructions until both source operands are known.
- Captures operands from the two common data buses (ALU result bus, LSB result bus).
- Dispatches one ready instruction per cycle to the ALU on the `work`/`op`/`rs1`/`rs2`/`imm`/`pc`/`rob_pos` interface, tagged with its ROB index.

Parameters:
- RS_SIZE, 16, number of entries (power of two, ≥2)
- ROB_W, 4, ROB index width
- OP_W, 6, internal opcode width (same encoding the ALU decodes)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- rdy  in  1  global enable; low = hold all state
- clear  in  1  synchronous flush (branch mispredict)
- issue_valid  in  1  decoder presents an instruction
- issue_op  in  OP_W  opcode
- issue_pc  in  32  instruction PC
- issue_imm  in  32  sign-extended immediate
- issue_rob_pos  in  ROB_W  destination ROB index
- issue_qj_busy  in  1  rs1 value not yet available
- issue_qj  in  ROB_W  ROB tag producing rs1
- issue_vj  in  32  rs1 value (valid when !issue_qj_busy)
- issue_qk_busy / issue_qk / issue_vk  in  1 / ROB_W / 32  same for rs2 (immediate ops issue qk_busy=0)
- alu_cdb_valid / alu_cdb_rob / alu_cdb_val  in  1 / ROB_W / 32  ALU result broadcast
- lsb_cdb_valid / lsb_cdb_rob / lsb_cdb_val  in  1 / ROB_W / 32  load result broadcast
- rs_full  out  1  no free entry; decoder must not issue
- alu_work  out  1  dispatch strobe, one cycle per instruction
- alu_op  out  OP_W  dispatched opcode
- alu_pc  out  32  dispatched PC
- alu_rs1 / alu_rs2  out  32  operand values
- alu_imm  out  32  immediate
- alu_rob_pos  out  ROB_W  ROB tag of dispatched instruction

Behaviour:
- Entry state: busy, op, pc, imm, rob_pos, qj_busy/qj/vj, qk_busy/qk/vk.
- rs_full = (occupancy == RS_SIZE); combinational from registered occupancy.

Reset (rst_n low, async):
- All entries not busy; occupancy 0.
- alu_work = 0; all alu_* data outputs = 0; rs_full = 0.

rdy low:
- No state changes; alu_work registered to 0.
- Issue and CDB inputs that cycle are ignored; upstream holds them.

clear high at an edge (with rdy):
- All entries freed, occupancy 0, alu_work = 0 next cycle.
- clear has priority over issue, wakeup and dispatch.

Issue (issue_valid && !rs_full at edge E):
- Write into the lowest-index free entry.
- If issue_qj_busy and a CDB in the same cycle carries tag issue_qj: store that CDB value with qj_busy = 0 (issue-time bypass). Same for qk. ALU CDB is checked before LSB CDB; both cannot match the same tag.
- issue_valid while rs_full: ignored, no state change.

Wakeup (CDB valid at edge E):
- Every busy entry whose qj_busy && qj == tag captures the value and clears qj_busy. Same for qk.
- Both operands of one entry may wake from different buses in the same edge.

Dispatch:
- Ready = busy && !qj_busy && !qk_busy, evaluated on registered state.
- At each edge, the lowest-index ready entry is copied to the alu_* registers, alu_work = 1, and the entry is freed.
- With no ready entry, alu_work = 0 and alu_* hold their previous values.

Latency:
- Instruction issued ready at edge E → alu_work high during the cycle after E+1.
- Operand woken at edge E → dispatch no earlier than edge E+1.
- Never dispatch in the same edge as issue or wakeup.

Occupancy:
- Same-edge issue + dispatch: unchanged.
- Issue only: +1. Dispatch only: −1.
- The freed slot is reusable from the next edge.

Ordering:
- Ready selection is by lowest index, not age. ROB restores program order.
- Each rob_pos is dispatched exactly once.

Test Plan:
- Reset then issue ADDI (rs1 ready vj=5, imm=7, rob 3) → next cycle alu_work=1, alu_rs1=5, alu_imm=7, alu_rob_pos=3; following cycle alu_work=0.
- Issue ADD with qj_busy tag 2, vk=10; three cycles later alu_cdb rob=2 val=0x20 → alu_work one cycle after the broadcast with alu_rs1=0x20, alu_rs2=10; no earlier alu_work.
- Issue-time bypass: issue SUB with qk tag 6 while lsb_cdb_valid rob=6 val=9 in the same cycle → dispatched next cycle with alu_rs2=9.
- Fill 16 dependent entries (all waiting on tag 1) → rs_full=1 and a 17th issue is ignored; broadcast tag 1 → 16 consecutive alu_work cycles, indices 0..15 in order, rs_full drops after the first dispatch.
- With 4 waiting entries, pulse clear together with a matching CDB and a new issue → occupancy 0, rs_full=0, no alu_work afterward.
- Hold rdy=0 for 3 cycles with a ready entry → alu_work stays 0; on rdy=1 it dispatches once. Assert rst_n low mid-run → alu_work=0 immediately, all entries dropped.
